cpu_trace_buffer: RTL

//  Downstream observer of CPU_single: on every retired instruction, captures the record
//  {Pc, Inst, ALU_out} into an on-chip FIFO, starting from a programmable trigger PC.

---
 rtl/cpu_trace_pkg.sv | 35 +++
 rtl/cpu_trace_buffer_if.sv | 15 +
 rtl/trace_fifo.sv | 69 ++++++
 rtl/cpu_trace_buffer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// ---------------------------------------------------------------------------
// cpu_trace_pkg
//   Shared definitions for the CPU trace buffer: FSM state encodings, record
//   geometry, word-index constants and the record-to-word selector.
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  localparam int REC_W         = 96;
  localparam int WORDS_PER_REC = 3;

  // Word order on the output stream: PC first, ALU result closes the record.
  localparam logic [1:0] W_PC   = 2'd0;
  localparam logic [1:0] W_INST = 2'd1;
  localparam logic [1:0] W_ALU  = 2'(WORDS_PER_REC - 1);

  // Record layout is {Pc, Inst, ALU_out}, Pc in the top 32 bits.
  function automatic logic [31:0] rec_word(input logic [REC_W-1:0] rec,
                                           input logic [1:0]       idx);
    logic [31:0] w;
    case (idx)
      W_PC:    w = rec[95:64];
      W_INST:  w = rec[63:32];
      W_ALU:   w = rec[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer_if
//   Word stream from the trace buffer to the debug/UART consumer.
//   Out_valid/Out_data/Out_last : driven by the buffer (master)
//   Out_ready                   : driven by the consumer (slave)
// ---------------------------------------------------------------------------
interface cpu_trace_buffer_if;
  logic        Out_valid;
  logic [31:0] Out_data;
  logic        Out_last;
  logic        Out_ready;

  modport master (output Out_valid, output Out_data, output Out_last, input Out_ready);
  modport slave  (input Out_valid, input Out_data, input Out_last, output Out_ready);
endinterface

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
//   Synchronous record FIFO, REC_W bits wide, DEPTH entries.
//   clk_i/rst_ni   : clock, asynchronous active-low reset
//   push_i/data_i  : write request and record; accepted when not full, or
//                    when full and a pop happens in the same cycle
//   pop_i          : remove head (ignored when empty)
//   full_o/empty_o : current occupancy flags
//   count_nxt_o    : occupancy after this edge
//   head_nxt_o     : head record after this edge (valid when count_nxt_o != 0)
// ---------------------------------------------------------------------------
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [REC_W-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_nxt_o,
  output logic [REC_W-1:0] head_nxt_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d, count_s;
  logic             pop_ok_s, push_ok_s;

  assign count_s   = wr_q - rd_q;
  assign full_o    = (count_s == DEPTH_C);
  assign empty_o   = (count_s == '0);
  assign pop_ok_s  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  assign wr_d        = wr_q + {{AW{1'b0}}, push_ok_s};
  assign rd_d        = rd_q + {{AW{1'b0}}, pop_ok_s};
  assign count_nxt_o = wr_d - rd_d;

  // The incoming record becomes the head only when it lands in the slot the
  // read pointer is about to point at (FIFO empty after any pop).
  assign head_nxt_o = (push_ok_s && (wr_q[AW-1:0] == rd_d[AW-1:0])) ? data_i
                                                                     : mem_q[rd_d[AW-1:0]];

  // Read/write pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer
//   Captures {Pc, Inst, ALU_out} of every retired instruction once a trigger
//   fires and streams each record out as three 32-bit words.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   Pc/Inst/ALU_out     : retiring instruction, qualified by Retire
//   Arm/Stop            : control pulses (Stop has priority)
//   Trig_any/Trig_pc    : trigger on first retire, or on a matching PC
//   out_if (master)     : Out_valid/Out_data/Out_last/Out_ready word stream
//   Count               : records stored, 0..DEPTH
//   Dropped/Drop_cnt    : sticky loss flag, saturating loss counter
//   State               : 00 IDLE, 01 ARMED, 10 RUN
// ---------------------------------------------------------------------------
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [31:0]         Pc,
  input  logic [31:0]         Inst,
  input  logic [31:0]         ALU_out,
  input  logic                Retire,
  input  logic                Arm,
  input  logic                Stop,
  input  logic                Trig_any,
  input  logic [31:0]         Trig_pc,
  cpu_trace_buffer_if.master  out_if,
  output logic [AW:0]         Count,
  output logic                Dropped,
  output logic [7:0]          Drop_cnt,
  output logic [1:0]          State
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [AW:0] count_q, count_d;
  logic        dropped_q, dropped_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic             hs_s, pop_s, hit_s, push_s, drop_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [AW:0]      fifo_count_nxt_s;
  logic [REC_W-1:0] fifo_head_nxt_s;

  assign hs_s   = out_valid_q && out_if.Out_ready;
  assign pop_s  = hs_s && (idx_q == W_ALU) && !fifo_empty_s;
  assign hit_s  = Retire && (Trig_any || (Pc == Trig_pc));
  // The triggering instruction is itself captured; Stop suppresses capture.
  assign push_s = !Stop && Retire &&
                  ((state_q == ST_RUN) || ((state_q == ST_ARMED) && hit_s));
  assign drop_s = push_s && fifo_full_s && !pop_s;

  trace_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .push_i      (push_s),
    .data_i      ({Pc, Inst, ALU_out}),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_nxt_o (fifo_count_nxt_s),
    .head_nxt_o  (fifo_head_nxt_s)
  );

  // Next-state logic: FSM, word index, drop statistics, registered stream outputs.
  always_comb begin
    state_d = state_q;
    if (Stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Arm) state_d = ST_ARMED;
          else     state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (hit_s) state_d = ST_RUN;
          else       state_d = ST_ARMED;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    idx_d = idx_q;
    if (hs_s) begin
      if (idx_q == W_ALU) idx_d = W_PC;
      else                idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end

    dropped_d  = dropped_q;
    drop_cnt_d = drop_cnt_q;
    if (Arm && !Stop) begin
      dropped_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop_s) begin
      dropped_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      else                     drop_cnt_d = drop_cnt_q;
    end else begin
      dropped_d  = dropped_q;
      drop_cnt_d = drop_cnt_q;
    end

    // Outputs are precomputed from next-state so they leave straight from flops.
    count_d     = fifo_count_nxt_s;
    out_valid_d = (fifo_count_nxt_s != '0);
    if (out_valid_d) begin
      out_data_d = rec_word(fifo_head_nxt_s, idx_d);
      out_last_d = (idx_d == W_ALU);
    end else begin
      out_data_d = 32'h0000_0000;
      out_last_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= W_PC;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_last_q  <= 1'b0;
      count_q     <= '0;
      dropped_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
      dropped_q   <= dropped_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_if.Out_valid = out_valid_q;
  assign out_if.Out_data  = out_data_q;
  assign out_if.Out_last  = out_last_q;
  assign Count            = count_q;
  assign Dropped          = dropped_q;
  assign Drop_cnt         = drop_cnt_q;
  assign State            = state_q;

endmodule
